// File: rtl/divide_10_if.sv
// rtl/divide_10_if.sv - start/done handshake and result bus for the divide-by-ten unit
// The controller drives start and dividend; the divider returns quotient, remainder and done.
interface divide_10_if;
  logic        start;
  logic [13:0] dividend;
  logic [9:0]  quotient;
  logic [13:0] remainder;
  logic        done;

  modport master (
    output start,
    output dividend,
    input  quotient,
    input  remainder,
    input  done
  );

  modport slave (
    input  start,
    input  dividend,
    output quotient,
    output remainder,
    output done
  );
endinterface

// File: rtl/divide_10.sv
// rtl/divide_10.sv - sequential unsigned divide-by-ten by repeated subtraction
// Splits a 14-bit value into quotient (mod 1024) and remainder 0..9, one subtraction per clock.
module divide_10 (
  input  logic       clk,
  input  logic       rst_n,
  divide_10_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_quotient;
  logic [13:0] r_remainder;
  logic        r_done;
  logic        w_ge_ten;

  assign w_ge_ten = (r_remainder >= 14'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_quotient  <= 10'd0;
      r_remainder <= 14'd0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          // Without start the previous result stays on the outputs for the display.
          if (bus.start) begin
            r_remainder <= bus.dividend;
            r_quotient  <= 10'd0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (w_ge_ten) begin
            r_remainder <= r_remainder - 14'd10;
            r_quotient  <= r_quotient + 10'd1;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // A held start must not retrigger; the controller has to drop it first.
          if (!bus.start) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_divide_10.sv
// tb/tb_divide_10.sv - self-checking bench for divide_10
// Vector table plus reset, held-start and disturbed-input sequences, checked through a scoreboard.
module tb_divide_10;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  divide_10_if bus ();

  divide_10 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [13:0] d;
    logic [9:0]  q;
    logic [13:0] r;
  } vec_t;

  typedef struct {
    logic [9:0]  q;
    logic [13:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a request and record what the result must be once done rises.
  task automatic load(input logic [13:0] d);
    exp_t e;
    @(negedge clk);
    bus.dividend = d;
    bus.start    = 1'b1;
    e.q   = 10'((int'(d) / 10) % 1024);
    e.r   = 14'(int'(d) % 10);
    e.lat = int'(d) / 10 + 2;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input bit disturb);
    int   edges;
    exp_t e;
    edges = 0;
    while (!bus.done && edges < 2000) begin
      @(posedge clk);
      #1;
      edges++;
      if (disturb && !bus.done && edges >= 2) begin
        bus.dividend = 14'($urandom);
        bus.start    = ~bus.start;
      end
    end
    if (disturb) bus.start = 1'b1;
    chk({name, " done_seen"}, bus.done, 1'b1);
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s scoreboard: got 0 entries expected 1", name);
    end else begin
      e = sb.pop_front();
      chk({name, " latency"}, edges, e.lat);
      chk({name, " quotient"}, bus.quotient, e.q);
      chk({name, " remainder"}, bus.remainder, e.r);
    end
  endtask

  task automatic release_start(input string name);
    logic [9:0]  q;
    logic [13:0] r;
    q = bus.quotient;
    r = bus.remainder;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " done_drop"}, bus.done, 1'b0);
    chk({name, " q_held"}, bus.quotient, q);
    chk({name, " r_held"}, bus.remainder, r);
  endtask

  initial begin
    logic [9:0] q_keep;

    vecs[0] = '{14'd34,    10'd3,    14'd4};
    vecs[1] = '{14'd0,     10'd0,    14'd0};
    vecs[2] = '{14'd9,     10'd0,    14'd9};
    vecs[3] = '{14'd10239, 10'd1023, 14'd9};
    vecs[4] = '{14'd16383, 10'd614,  14'd3};
    vecs[5] = '{14'd57,    10'd5,    14'd7};
    vecs[6] = '{14'd10,    10'd1,    14'd0};
    vecs[7] = '{14'd123,   10'd12,   14'd3};

    bus.start    = 1'b0;
    bus.dividend = 14'd0;
    rst_n        = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset quotient", bus.quotient, 10'd0);
    chk("reset remainder", bus.remainder, 14'd0);
    chk("reset done", bus.done, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      load(vecs[i].d);
      wait_done($sformatf("vec%0d", i), 1'b0);
      chk($sformatf("vec%0d table_q", i), bus.quotient, vecs[i].q);
      chk($sformatf("vec%0d table_r", i), bus.remainder, vecs[i].r);
      if (i == 0) begin
        q_keep = bus.quotient;
        repeat (5) begin
          @(posedge clk);
          #1;
          chk("held start done", bus.done, 1'b1);
        end
        chk("held start q", bus.quotient, q_keep);
      end
      release_start($sformatf("vec%0d", i));
    end

    load(14'd345);
    wait_done("disturb", 1'b1);
    release_start("disturb");

    load(14'd500);
    repeat (10) @(posedge clk);
    #1;
    chk("midbusy q", bus.quotient, 10'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset q", bus.quotient, 10'd0);
    chk("async reset r", bus.remainder, 14'd0);
    chk("async reset done", bus.done, 1'b0);
    sb.delete();
    begin
      exp_t e;
      e.q   = 10'd50;
      e.r   = 14'd0;
      e.lat = 52;
      sb.push_back(e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("restart", 1'b0);
    release_start("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide_10.md
Name: divide_10

Overview:
Sequential unsigned divide-by-ten unit. It converts a 14-bit binary value into a quotient and a remainder by repeated subtraction of 10. It sits in the display path, where it splits a binary count into decimal digits. A start/done handshake lets a controller step through digits one division at a time.

Parameters:
none (divisor fixed at 10; widths fixed: dividend 14, quotient 10, remainder 14)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level request; sampled only in IDLE
dividend  input  14  unsigned value to divide; captured on the load edge
quotient  output  10  running/final quotient, registered
remainder  output  14  running/final remainder (final value 0..9), registered
done  output  1  high while a finished result is held

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE, quotient=0, remainder=0, done=0, immediately.
  - Normal operation resumes on the first rising edge after rst_n=1.
- States: IDLE, BUSY, DONE.
- IDLE:
  - done=0.
  - On an edge with start=1: remainder<=dividend, quotient<=0, go BUSY.
  - With start=0: hold all outputs, so the previous result stays visible.
- BUSY:
  - Each edge with remainder>=10: remainder<=remainder-10, quotient<=quotient+1 (10-bit, wraps mod 1024).
  - First edge with remainder<10: done<=1, go DONE; quotient and remainder unchanged.
  - start and dividend are ignored; dividend changes do not affect the operation.
  - Outputs show running values; done=0 throughout.
- DONE:
  - done=1; quotient and remainder held.
  - Stays in DONE while start=1, so a held start never retriggers.
  - On an edge with start=0: go IDLE, done<=0, results still held.
- Latency: counting the load edge as edge 1, done rises on edge floor(d/10)+2.
  - d=34: done after edge 5.
  - d<10: done after edge 2.
  - Worst case d=16383: 1640 edges.
- Arithmetic: unsigned only; compare and subtract at full 14-bit width; the final remainder is always dividend mod 10.
- Range: quotient is exact for dividend<=10239. Above that, quotient=floor(d/10) mod 1024 and remainder is still correct. No overflow flag.
- New operation: requires a return to IDLE (start low for at least one edge), then start high again.

Test Plan:
- Reset, dividend=34, start=1 held -> done=1 after 5th edge; quotient=3, remainder=4; done stays 1 while start stays 1.
- dividend=0 and dividend=9 -> done after 2nd edge; q=0, r=0 and q=0, r=9 respectively.
- dividend=10239 -> q=1023, r=9 after 1025 edges; dividend=16383 -> q=614 (wrapped), r=3.
- During BUSY, change dividend and toggle start -> result still reflects the originally loaded value.
- Drop start in DONE -> done=0 next edge, q/r held; raise start with dividend=57 -> q=5, r=7.
- Assert rst_n=0 mid-BUSY (dividend=500) -> q=0, r=0, done=0 immediately, without waiting for a clock edge; release with start=1 -> clean restart, result correct.
